// File: rtl/apb_cmd_master.sv
// rtl/apb_cmd_master.sv - APB initiator fed by a command FIFO, one response pulse per command
module apb_cmd_master #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int CMD_DEPTH   = 4,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic              rsp_write,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  output logic              pwrite,
  output logic              psel,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  output logic              penable,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready
);

  localparam int PW     = $clog2(CMD_DEPTH);
  localparam int CNT_W  = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam int TLIM_I = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;
  localparam logic [CNT_W-1:0] TLIM = CNT_W'(TLIM_I);
  localparam logic [CNT_W-1:0] TMAX = CNT_W'(TIMEOUT_CYC);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t state, state_n;

  logic              mem_write [CMD_DEPTH];
  logic [ADDR_W-1:0] mem_addr  [CMD_DEPTH];
  logic [DATA_W-1:0] mem_wdata [CMD_DEPTH];

  logic [PW:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0] tcnt;
  logic             empty, full, push, pop, done, abort, timeout_hit;

  // Wrap bit distinguishes full from empty when the index bits match.
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign cmd_ready = !full;
  assign push      = cmd_valid && cmd_ready;
  assign busy      = (state != IDLE) || !empty;

  assign timeout_hit = (TIMEOUT_CYC > 0) && (tcnt == TLIM);

  always_comb begin
    state_n = state;
    pop     = 1'b0;
    done    = 1'b0;
    abort   = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_n = SETUP;
        end
      end
      SETUP: state_n = ACCESS;
      ACCESS: begin
        if (pready) begin
          done = 1'b1;
          if (!empty) begin
            pop     = 1'b1;
            state_n = SETUP;
          end else begin
            state_n = IDLE;
          end
        end else if (timeout_hit) begin
          abort   = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_write[wr_ptr[PW-1:0]] <= cmd_write;
      mem_addr[wr_ptr[PW-1:0]]  <= cmd_addr;
      mem_wdata[wr_ptr[PW-1:0]] <= cmd_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      tcnt    <= '0;
      psel    <= 1'b0;
      penable <= 1'b0;
      pwrite  <= 1'b0;
      paddr   <= '0;
      pwdata  <= '0;
    end else begin
      state <= state_n;
      if (push) wr_ptr <= wr_ptr + {{PW{1'b0}}, 1'b1};
      if (pop)  rd_ptr <= rd_ptr + {{PW{1'b0}}, 1'b1};

      case (state)
        SETUP: begin
          penable <= 1'b1;
          tcnt    <= '0;
        end
        ACCESS: begin
          if (!pready && tcnt != TMAX) tcnt <= tcnt + 1'b1;
          if (done || abort) begin
            psel    <= 1'b0;
            penable <= 1'b0;
          end
        end
        default: ;
      endcase

      // A pop overrides the completion drop so back-to-back transfers keep psel high.
      if (pop) begin
        psel    <= 1'b1;
        penable <= 1'b0;
        pwrite  <= mem_write[rd_ptr[PW-1:0]];
        paddr   <= mem_addr[rd_ptr[PW-1:0]];
        pwdata  <= mem_wdata[rd_ptr[PW-1:0]];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_write <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= done || abort;
      if (done) begin
        rsp_write <= pwrite;
        rsp_rdata <= pwrite ? '0 : prdata;
        rsp_err   <= 1'b0;
      end else if (abort) begin
        rsp_write <= pwrite;
        rsp_rdata <= '0;
        rsp_err   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_apb_cmd_master.sv
// tb/tb_apb_cmd_master.sv - directed self-checking bench for apb_cmd_master
module tb_apb_cmd_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_write, rsp_err, busy;
  logic [31:0] rsp_rdata;
  logic        pwrite, psel, penable, pready;
  logic [31:0] paddr, pwdata, prdata, prdata_drv;
  logic        echo_mode;

  int total = 0;
  int bad   = 0;
  int psel_cyc, pen_cyc;
  logic        rq_w [$];
  logic [31:0] rq_d [$];
  logic        rq_e [$];

  always #5 clk = ~clk;

  // Reads in echo mode return ~paddr so response order is visible in the data.
  assign prdata = echo_mode ? ~paddr : prdata_drv;

  apb_cmd_master #(.ADDR_W(32), .DATA_W(32), .CMD_DEPTH(4), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .busy(busy), .pwrite(pwrite), .psel(psel), .paddr(paddr), .pwdata(pwdata),
    .penable(penable), .prdata(prdata), .pready(pready)
  );

  always @(negedge clk) begin
    if (psel) psel_cyc++;
    if (penable) pen_cyc++;
    if (rsp_valid) begin
      rq_w.push_back(rsp_write);
      rq_d.push_back(rsp_rdata);
      rq_e.push_back(rsp_err);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_mon();
    psel_cyc = 0; pen_cyc = 0;
    rq_w.delete(); rq_d.delete(); rq_e.delete();
  endtask

  task automatic push(input logic w, input logic [31:0] a, input logic [31:0] d);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    tick();
    cmd_valid = 1'b0; cmd_addr = 32'hDEAD_BEEF; cmd_wdata = 32'hDEAD_BEEF;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready got %b want 1", cmd_ready); end
    total++; if ({psel, penable, pwrite, rsp_valid, rsp_err, busy} !== 6'b0) begin bad++;
      $display("FAIL reset_ctrl got %b want 000000", {psel, penable, pwrite, rsp_valid, rsp_err, busy}); end
    total++; if ({paddr, pwdata, rsp_rdata} !== 96'h0) begin bad++;
      $display("FAIL reset_data got %h want 0", {paddr, pwdata, rsp_rdata}); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_write();
    pready = 1'b1; echo_mode = 1'b0; prdata_drv = 32'hFFFF_FFFF;
    clear_mon();
    push(1'b1, 32'h0000_0010, 32'hA5A5_A5A5);
    total++; if ({busy, psel} !== 2'b10) begin bad++; $display("FAIL wr_queued busy,psel got %b want 10", {busy, psel}); end
    tick();
    total++; if ({psel, penable, pwrite} !== 3'b101) begin bad++; $display("FAIL wr_setup got %b want 101", {psel, penable, pwrite}); end
    total++; if ({paddr, pwdata} !== {32'h0000_0010, 32'hA5A5_A5A5}) begin bad++;
      $display("FAIL wr_setup_bus got %h want 00000010a5a5a5a5", {paddr, pwdata}); end
    tick();
    total++; if ({psel, penable} !== 2'b11) begin bad++; $display("FAIL wr_access got %b want 11", {psel, penable}); end
    tick();
    total++; if ({rsp_valid, rsp_write, rsp_err, psel, penable} !== 5'b11000) begin bad++;
      $display("FAIL wr_rsp got %b want 11000", {rsp_valid, rsp_write, rsp_err, psel, penable}); end
    total++; if (rsp_rdata !== 32'h0) begin bad++; $display("FAIL wr_rsp_rdata got %h want 0", rsp_rdata); end
    tick();
    total++; if ({rsp_valid, busy} !== 2'b00) begin bad++; $display("FAIL wr_after got %b want 00", {rsp_valid, busy}); end
    total++; if (psel_cyc !== 2 || pen_cyc !== 1) begin bad++;
      $display("FAIL wr_cycles got psel=%0d pen=%0d want psel=2 pen=1", psel_cyc, pen_cyc); end
  endtask

  task automatic test_read_wait();
    pready = 1'b0; echo_mode = 1'b0; prdata_drv = 32'hFFFF_0000;
    clear_mon();
    push(1'b0, 32'h0000_0020, 32'h0);
    tick(); tick();
    tick(); tick(); tick();
    total++; if ({psel, penable, rsp_valid} !== 3'b110) begin bad++;
      $display("FAIL rd_waiting got %b want 110", {psel, penable, rsp_valid}); end
    pready = 1'b1; prdata_drv = 32'h1234_5678;
    tick();
    prdata_drv = 32'h0;
    total++; if ({rsp_valid, rsp_write, rsp_err} !== 3'b100) begin bad++;
      $display("FAIL rd_rsp got %b want 100", {rsp_valid, rsp_write, rsp_err}); end
    total++; if (rsp_rdata !== 32'h1234_5678) begin bad++; $display("FAIL rd_rdata got %h want 12345678", rsp_rdata); end
    tick();
    total++; if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h1234_5678) begin bad++;
      $display("FAIL rd_hold got v=%b d=%h want v=0 d=12345678", rsp_valid, rsp_rdata); end
    total++; if (pen_cyc !== 4) begin bad++; $display("FAIL rd_pen_cycles got %0d want 4", pen_cyc); end
  endtask

  task automatic test_full_fifo();
    int acc = 0;
    int n_rsp = 0;
    pready = 1'b0; echo_mode = 1'b1;
    tick(); clear_mon();
    // One command goes in flight, so five are taken before the FIFO fills.
    for (int i = 0; i < 6; i++) begin
      cmd_valid = 1'b1; cmd_write = (i == 2); cmd_addr = 32'h100 + 4 * i; cmd_wdata = i;
      if (cmd_ready) acc++;
      if (i == 5) begin
        total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL full_ready got %b want 0", cmd_ready); end
      end
      tick();
    end
    cmd_valid = 1'b0;
    total++; if (acc !== 5) begin bad++; $display("FAIL full_accepted got %0d want 5", acc); end
    pready = 1'b1;
    for (int c = 0; c < 40 && n_rsp < 5; c++) begin
      tick();
      if (rsp_valid) n_rsp++;
      if (n_rsp < 5) begin
        total++; if (psel !== 1'b1) begin bad++; $display("FAIL full_psel_gap cycle %0d got %b want 1", c, psel); end
      end
    end
    tick();
    total++; if (rq_d.size() !== 5) begin bad++; $display("FAIL full_rsp_count got %0d want 5", rq_d.size()); end
    for (int i = 0; i < 5 && i < rq_d.size(); i++) begin
      logic [31:0] a;
      logic [31:0] exp_d;
      a = 32'h100 + 4 * i;
      exp_d = (i == 2) ? 32'h0 : ~a;
      total++; if (rq_d[i] !== exp_d || rq_w[i] !== (i == 2) || rq_e[i] !== 1'b0) begin bad++;
        $display("FAIL full_order %0d got w=%b d=%h e=%b want w=%b d=%h e=0", i, rq_w[i], rq_d[i], rq_e[i], (i == 2), exp_d); end
    end
  endtask

  task automatic test_timeout();
    int got = 0;
    pready = 1'b0; echo_mode = 1'b1;
    tick(); clear_mon();
    push(1'b0, 32'h40, 32'h0);
    push(1'b1, 32'h44, 32'h5555_AAAA);
    for (int c = 0; c < 30 && !got; c++) begin
      tick();
      if (rsp_valid) got = 1;
    end
    total++; if (!got) begin bad++; $display("FAIL to_no_abort got none want abort"); end
    total++; if ({rsp_err, rsp_write, psel, penable} !== 4'b1000 || rsp_rdata !== 32'h0) begin bad++;
      $display("FAIL to_abort got e,w,psel,pen=%b d=%h want 1000 d=0", {rsp_err, rsp_write, psel, penable}, rsp_rdata); end
    total++; if (pen_cyc !== 8) begin bad++; $display("FAIL to_pen_cycles got %0d want 8", pen_cyc); end
    pready = 1'b1; got = 0;
    for (int c = 0; c < 10 && !got; c++) begin
      tick();
      if (rsp_valid) got = 1;
    end
    total++; if (!got || {rsp_err, rsp_write} !== 2'b01 || rsp_rdata !== 32'h0) begin bad++;
      $display("FAIL to_next got v=%0d e,w=%b d=%h want v=1 e,w=01 d=0", got, {rsp_err, rsp_write}, rsp_rdata); end
  endtask

  task automatic test_reset_mid();
    pready = 1'b0; echo_mode = 1'b1;
    tick(); clear_mon();
    push(1'b1, 32'h80, 32'h1);
    push(1'b1, 32'h84, 32'h2);
    tick();
    total++; if ({psel, penable} !== 2'b11) begin bad++; $display("FAIL rm_access got %b want 11", {psel, penable}); end
    #2 rst_n = 1'b0;
    #1;
    total++; if ({psel, penable, cmd_ready, busy} !== 4'b0010) begin bad++;
      $display("FAIL rm_async got psel,pen,ready,busy=%b want 0010", {psel, penable, cmd_ready, busy}); end
    tick(); tick();
    rst_n = 1'b1; pready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      total++; if ({rsp_valid, psel} !== 2'b00) begin bad++; $display("FAIL rm_after cycle %0d got %b want 00", c, {rsp_valid, psel}); end
    end
  endtask

  task automatic test_push_pop_occ3();
    logic [31:0] addrs [5];
    addrs[0] = 32'h200; addrs[1] = 32'h204; addrs[2] = 32'h208; addrs[3] = 32'h20C; addrs[4] = 32'h210;
    pready = 1'b0; echo_mode = 1'b1;
    tick(); clear_mon();
    for (int i = 0; i < 4; i++) push(i == 2, addrs[i], 32'h0);
    total++; if ({cmd_ready, psel, penable} !== 3'b111) begin bad++;
      $display("FAIL pp_pre got ready,psel,pen=%b want 111", {cmd_ready, psel, penable}); end
    pready = 1'b1;
    push(1'b0, addrs[4], 32'h0);
    total++; if ({cmd_ready, psel, penable} !== 3'b110) begin bad++;
      $display("FAIL pp_occ3 got ready,psel,pen=%b want 110", {cmd_ready, psel, penable}); end
    for (int c = 0; c < 15; c++) tick();
    total++; if (rq_d.size() !== 5 || busy !== 1'b0) begin bad++;
      $display("FAIL pp_count got n=%0d busy=%b want n=5 busy=0", rq_d.size(), busy); end
    for (int i = 0; i < 5 && i < rq_d.size(); i++) begin
      logic [31:0] exp_d;
      exp_d = (i == 2) ? 32'h0 : ~addrs[i];
      total++; if (rq_d[i] !== exp_d || rq_w[i] !== (i == 2)) begin bad++;
        $display("FAIL pp_order %0d got w=%b d=%h want w=%b d=%h", i, rq_w[i], rq_d[i], (i == 2), exp_d); end
    end
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    pready = 1'b0; prdata_drv = '0; echo_mode = 1'b0;
    test_reset();
    test_single_write();
    test_read_wait();
    test_full_fifo();
    test_timeout();
    test_reset_mid();
    test_push_pop_occ3();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
